// File: rtl/lc3_mem_master.sv
// lc3_mem_master: memory-side initiator for the LC-3 core.
// It accepts one read or write request at a time over a valid/ready
// handshake. The combinational SRAM strobe is held for WAIT_STATES+1 cycles,
// then the SRAM output is sampled and returned over a response handshake.
//
// Build option: define LC3_MEMIF_POSTED_WRITE_EN to make writes posted.
// A posted write returns straight to IDLE and produces no response.
// Reads are not affected by this option.
module lc3_mem_master #(
    parameter int WAIT_STATES = 1      // extra strobe cycles, 0..15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_address,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic [15:0] sram_address,
    output logic [15:0] sram_data,
    output logic        sram_write_enable,
    output logic        sram_output_enable,
    input  logic [15:0] sram_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // The wait counter is four bits wide, so WAIT_STATES is truncated to that width.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    logic [1:0] state_reg;
    logic [3:0] wait_cnt_reg;

    // req_ready is decoded from the state only. Reset forces the state to IDLE
    // asynchronously, so req_ready reads 1 while reset is held.
    assign req_ready = (state_reg == ST_IDLE);

`ifdef LC3_MEMIF_POSTED_WRITE_EN
    logic write_reg;

    // Store the request direction so ACCESS can decide whether to skip RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && req_valid) begin
            write_reg <= req_write;
        end
    end
`endif

    // Main controller: the FSM, the wait counter, the SRAM port registers and the response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= ST_IDLE;
            wait_cnt_reg       <= 4'd0;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= 16'h0000;
            sram_address       <= 16'h0000;
            sram_data          <= 16'h0000;
            sram_write_enable  <= 1'b0;
            sram_output_enable <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // The address and data are registered here. They keep their values until the next accept.
                    if (req_valid) begin
                        sram_address       <= req_address;
                        sram_data          <= req_wdata;
                        sram_write_enable  <= req_write;
                        sram_output_enable <= !req_write;
                        wait_cnt_reg       <= WAIT_LOAD;
                        state_reg          <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt_reg != 4'd0) begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end else begin
                        // This is the last strobe cycle. Drop both strobes now.
                        sram_write_enable  <= 1'b0;
                        sram_output_enable <= 1'b0;
`ifdef LC3_MEMIF_POSTED_WRITE_EN
                        if (write_reg) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            rsp_rdata <= sram_rdata;
                            rsp_valid <= 1'b1;
                            state_reg <= ST_RESP;
                        end
`else
                        // On a write the SRAM output follows its data input, so a write returns the write data.
                        rsp_rdata <= sram_rdata;
                        rsp_valid <= 1'b1;
                        state_reg <= ST_RESP;
`endif
                    end
                end
                ST_RESP: begin
                    // Go back to IDLE only. A new request is not accepted in the handshake cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg          <= ST_IDLE;
                    rsp_valid          <= 1'b0;
                    sram_write_enable  <= 1'b0;
                    sram_output_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lc3_mem_master.md
# lc3_mem_master

Memory-side initiator for the LC-3 core. It accepts single read/write requests from the core over a valid/ready handshake and drives the combinational SRAM port (address, data, write enable, output enable) for a fixed number of wait states. It samples the SRAM output and returns the result over a response handshake. It sits between the core's MAR/MDR logic and the `csram`-style memory.

## Interface

Parameters:
- `WAIT_STATES`, default 1: extra cycles the SRAM strobe is held before sampling; legal range 0..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: master can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_address` in 16: word address.
- `req_wdata` in 16: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: core accepts the response.
- `rsp_rdata` out 16: read data, or the write echo.
- `sram_address` out 16: to SRAM address.
- `sram_data` out 16: to SRAM data input.
- `sram_write_enable` out 1: SRAM write strobe.
- `sram_output_enable` out 1: SRAM read strobe.
- `sram_rdata` in 16: SRAM data output (combinational).

## Operation

- FSM states: IDLE, ACCESS, RESP.
- `req_ready` is 1 exactly when the state is IDLE. It is decoded from state, so it reads 1 during reset.
- IDLE:
  - On `req_valid & req_ready`, register `req_address`→`sram_address`, `req_wdata`→`sram_data` and `req_write`.
  - Set `sram_write_enable` = `req_write` and `sram_output_enable` = `!req_write`.
  - Load the wait counter (4 bits) with `WAIT_STATES`, then go to ACCESS.
- ACCESS:
  - Strobes, address and data are held stable.
  - Counter > 0: decrement it.
  - Counter == 0: capture `sram_rdata` into `rsp_rdata`, clear both strobes, set `rsp_valid`, go to RESP.
  - On writes the SRAM reflects the input data, so `rsp_rdata` equals the write data.
- RESP:
  - `rsp_valid` and `rsp_rdata` are held until `rsp_ready` = 1.
  - On `rsp_valid & rsp_ready`, clear `rsp_valid` and go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Exactly one of the strobes is high in ACCESS; both are low in IDLE and RESP.
- `sram_address` and `sram_data` retain their last values outside ACCESS.
- The counter never wraps: it is loaded only in IDLE and decremented only while nonzero.

## Timing

- Reset values:
  - state IDLE
  - `req_ready` 1
  - `rsp_valid` 0
  - `rsp_rdata` 0x0000
  - `sram_address` 0x0000
  - `sram_data` 0x0000
  - `sram_write_enable` 0
  - `sram_output_enable` 0
  - wait counter 0
- Reset mid-transaction: all outputs take their reset values immediately (asynchronously). The transaction is dropped and no response is produced.
- Request accepted at rising edge N:
  - Strobe high for cycles N+1 … N+1+`WAIT_STATES` (`WAIT_STATES`+1 cycles).
  - Capture at the edge ending cycle N+1+`WAIT_STATES`.
  - `rsp_valid` high from cycle N+2+`WAIT_STATES`.
- With `WAIT_STATES`=0: strobe high for 1 cycle; `rsp_valid` from cycle N+2.
- Minimum back-to-back request spacing (`rsp_ready` tied 1): `WAIT_STATES`+3 cycles.
- `rsp_ready` held low: `rsp_valid` and `rsp_rdata` remain stable indefinitely, and `req_ready` stays 0.

## Configuration

- `LC3_MEMIF_POSTED_WRITE_EN` defined:
  - Writes complete without a response. ACCESS goes directly to IDLE when the counter reaches 0; `rsp_valid` is not asserted and `rsp_rdata` is not updated.
  - Minimum write-to-next-request spacing is `WAIT_STATES`+2 cycles.
  - Reads are unchanged.
- Not defined: writes return a response exactly like reads, as described above.

## Test plan

- Read: `WAIT_STATES`=1, read 0x3000 with SRAM contents loaded → `sram_output_enable` high for 2 cycles with `sram_address`=0x3000; `rsp_valid` at N+3; `rsp_rdata`=0x9040.
- Unmapped read and back-to-back: read 0x3006 then 0x1234 with `rsp_ready`=1 → `rsp_rdata` 0x0FF9 then 0xFFFF; second accept exactly 4 cycles after the first.
- Write without macro: address 0x4000, data 0xABCD → `sram_write_enable` high 2 cycles, `sram_output_enable` 0 throughout; response `rsp_rdata`=0xABCD. With the macro: no `rsp_valid`, and `req_ready` returns 1 at N+3.
- Response backpressure: hold `rsp_ready`=0 for 10 cycles after `rsp_valid` → `rsp_valid` and `rsp_rdata` stable, `req_ready`=0, a pending `req_valid` is not accepted; release → IDLE the next cycle.
- `WAIT_STATES`=0 and `WAIT_STATES`=15: read 0x3001 → strobe widths 1 and 16 cycles respectively; `rsp_rdata`=0x5060 in both cases.
- Reset mid-access: assert `reset_n`=0 during the second ACCESS cycle → strobes drop without waiting for a clock edge; after release, `req_ready`=1, no spurious `rsp_valid`, and the next read of 0x3002 returns 0x1027.
